// File: rtl/activity_controller.sv
// Debounces four activity buttons into one exclusive state and emits one-second
// activity pulses plus a saturating active-seconds total for the fitness tracker.
module activity_controller #(
  parameter int unsigned TICK_DIV        = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_walk,
  input  logic        btn_cycle,
  input  logic        btn_stop,
  output logic        Run,
  output logic        Walk,
  output logic        Cycle,
  output logic [1:0]  active,
  output logic        sec_tick,
  output logic [15:0] active_seconds
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WALK  = 2'd2,
    CYCLE = 2'd3
  } state_e;

  localparam int B_RUN   = 0;
  localparam int B_WALK  = 1;
  localparam int B_CYCLE = 2;
  localparam int B_STOP  = 3;

  localparam logic [7:0]  DB_LIMIT = 8'(DEBOUNCE_CYCLES);
  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  logic [3:0]      btn_raw;
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0][7:0] cnt_q, cnt_d;
  logic [3:0]      db_q, db_d;
  logic [3:0]      press;
  state_e          state_q, state_d;
  logic [15:0]     div_q, div_d;
  logic [15:0]     active_seconds_q, active_seconds_d;
  logic            run_q, run_d, walk_q, walk_d, cycle_q, cycle_d;
  logic            sec_tick_q, sec_tick_d;
  logic            changed, tick;

  assign btn_raw = {btn_stop, btn_cycle, btn_walk, btn_run};

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = 8'd0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] + 8'd1 == DB_LIMIT) db_d[i] = sync2_q[i];
        else                             cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Presses are taken from the next debounced level so the state moves on the
  // same edge the button is accepted.
  assign press = db_d & ~db_q;

  always_comb begin
    state_d = state_q;
    if (press[B_STOP])       state_d = IDLE;
    else if (press[B_RUN])   state_d = (state_q == RUN)   ? IDLE : RUN;
    else if (press[B_WALK])  state_d = (state_q == WALK)  ? IDLE : WALK;
    else if (press[B_CYCLE]) state_d = (state_q == CYCLE) ? IDLE : CYCLE;
  end

  assign changed = (state_d != state_q);
  assign tick    = !changed && (state_q != IDLE) && (div_q == DIV_LAST);

  always_comb begin
    div_d            = div_q + 16'd1;
    active_seconds_d = active_seconds_q;
    if (changed || state_q == IDLE || div_q == DIV_LAST) div_d = 16'd0;
    if (tick && active_seconds_q != 16'hFFFF) active_seconds_d = active_seconds_q + 16'd1;
    sec_tick_d = tick;
    run_d      = tick && (state_q == RUN);
    walk_d     = tick && (state_q == WALK);
    cycle_d    = tick && (state_q == CYCLE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q          <= '0;
      sync2_q          <= '0;
      cnt_q            <= '0;
      db_q             <= '0;
      state_q          <= IDLE;
      div_q            <= '0;
      active_seconds_q <= '0;
      run_q            <= 1'b0;
      walk_q           <= 1'b0;
      cycle_q          <= 1'b0;
      sec_tick_q       <= 1'b0;
    end else begin
      sync1_q          <= btn_raw;
      sync2_q          <= sync1_q;
      cnt_q            <= cnt_d;
      db_q             <= db_d;
      state_q          <= state_d;
      div_q            <= div_d;
      active_seconds_q <= active_seconds_d;
      run_q            <= run_d;
      walk_q           <= walk_d;
      cycle_q          <= cycle_d;
      sec_tick_q       <= sec_tick_d;
    end
  end

  assign active         = state_q;
  assign Run            = run_q;
  assign Walk           = walk_q;
  assign Cycle          = cycle_q;
  assign sec_tick       = sec_tick_q;
  assign active_seconds = active_seconds_q;

endmodule

// File: tb/tb_activity_controller.sv
// Directed bench for activity_controller with TICK_DIV=10, DEBOUNCE_CYCLES=4.
// Outputs are observed 1 time unit after each rising edge.
module tb_activity_controller;

  localparam int TD = 10;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_run = 1'b0, btn_walk = 1'b0, btn_cycle = 1'b0, btn_stop = 1'b0;
  logic        run_o, walk_o, cycle_o, sec_tick;
  logic [1:0]  active;
  logic [15:0] active_seconds;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  activity_controller #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_run        (btn_run),
    .btn_walk       (btn_walk),
    .btn_cycle      (btn_cycle),
    .btn_stop       (btn_stop),
    .Run            (run_o),
    .Walk           (walk_o),
    .Cycle          (cycle_o),
    .active         (active),
    .sec_tick       (sec_tick),
    .active_seconds (active_seconds)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packed view {active, Run, Walk, Cycle, sec_tick, active_seconds}.
  function automatic logic [21:0] outs();
    return {active, run_o, walk_o, cycle_o, sec_tick, active_seconds};
  endfunction

  function automatic logic [21:0] ev(input logic [1:0] a, input logic r, input logic w,
                                     input logic c, input logic [15:0] s);
    return {a, r, w, c, (r | w | c), s};
  endfunction

  initial begin
    logic        r_exp;
    logic [15:0] s_exp;

    // Reset and idle
    step(3);
    check("reset_hold", outs(), ev(0, 0, 0, 0, 0));
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      check("idle", outs(), ev(0, 0, 0, 0, 0));
    end

    // Clean run press: first sampled at E1, active at E6, pulses after E16..E46
    btn_run = 1'b1;
    step(5);
    check("run_e5", outs(), ev(0, 0, 0, 0, 0));
    step(1);
    check("run_e6", outs(), ev(1, 0, 0, 0, 0));
    s_exp = 16'd0;
    for (int e = 7; e <= 55; e++) begin
      step(1);
      if (e == 20) btn_run = 1'b0;
      r_exp = (e >= 16) && ((e - 16) % TD == 0);
      if (r_exp) s_exp++;
      check("run_pulses", outs(), ev(1, r_exp, 0, 0, s_exp));
    end
    check("run_secs4", {6'd0, active_seconds}, 22'd4);

    // Stop press from RUN; a tick lands on E56 before the change at E61
    btn_stop = 1'b1;
    step(1);
    check("stop_e56", outs(), ev(1, 1, 0, 0, 5));
    step(4);
    check("stop_e60", outs(), ev(1, 0, 0, 0, 5));
    step(1);
    check("stop_e61", outs(), ev(0, 0, 0, 0, 5));
    btn_stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("stop_hold", outs(), ev(0, 0, 0, 0, 5));
    end

    // Bounce on walk: never stable for DEBOUNCE_CYCLES samples
    for (int i = 0; i < 20; i++) begin
      btn_walk = ((i / 2) % 2 == 0);
      step(1);
      check("bounce", outs(), ev(0, 0, 0, 0, 5));
    end
    btn_walk = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("bounce_after", outs(), ev(0, 0, 0, 0, 5));
    end

    // Switch RUN -> CYCLE on an edge where div is 7
    btn_run = 1'b1;
    step(5);
    check("sw_r5", outs(), ev(0, 0, 0, 0, 5));
    step(1);
    check("sw_r6", outs(), ev(1, 0, 0, 0, 5));
    step(2);
    btn_run   = 1'b0;
    btn_cycle = 1'b1;
    step(5);
    check("sw_r13", outs(), ev(1, 0, 0, 0, 5));
    check("sw_div7", {6'd0, dut.div_q}, 22'd7);
    step(1);
    check("sw_r14", outs(), ev(3, 0, 0, 0, 5));
    check("sw_div0", {6'd0, dut.div_q}, 22'd0);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check("cycle_first", outs(), ev(3, 0, 0, (k == 10), (k == 10) ? 16'd6 : 16'd5));
    end

    // Run and stop accepted on the same edge: stop wins
    btn_cycle = 1'b0;
    btn_run   = 1'b1;
    btn_stop  = 1'b1;
    step(5);
    check("prio_r29", outs(), ev(3, 0, 0, 0, 6));
    step(1);
    check("prio_r30", outs(), ev(0, 0, 0, 0, 6));
    btn_run  = 1'b0;
    btn_stop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("prio_hold", outs(), ev(0, 0, 0, 0, 6));
    end

    // Walk, then walk again pauses to IDLE
    btn_walk = 1'b1;
    step(6);
    check("walk_w6", outs(), ev(2, 0, 0, 0, 6));
    btn_walk = 1'b0;
    step(8);
    check("walk_w14", outs(), ev(2, 0, 0, 0, 6));
    btn_walk = 1'b1;
    step(2);
    check("walk_w16", outs(), ev(2, 0, 1, 0, 7));
    step(4);
    check("walk_toggle", outs(), ev(0, 0, 0, 0, 7));
    btn_walk = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("walk_hold", outs(), ev(0, 0, 0, 0, 7));
    end

    // Saturation: preload 65534 across a non-tick edge while in RUN
    btn_run = 1'b1;
    step(6);
    check("sat_s6", outs(), ev(1, 0, 0, 0, 7));
    btn_run = 1'b0;
    force dut.active_seconds_q = 16'd65534;
    step(1);
    release dut.active_seconds_q;
    check("sat_s7", outs(), ev(1, 0, 0, 0, 16'd65534));
    step(9);
    check("sat_s16", outs(), ev(1, 1, 0, 0, 16'hFFFF));
    step(1);
    check("sat_s17", outs(), ev(1, 0, 0, 0, 16'hFFFF));
    step(9);
    check("sat_s26", outs(), ev(1, 1, 0, 0, 16'hFFFF));
    step(10);
    check("sat_s36", outs(), ev(1, 1, 0, 0, 16'hFFFF));

    // Asynchronous reset while a pulse is high
    rst = 1'b0;
    #1;
    check("rst_async", outs(), ev(0, 0, 0, 0, 0));
    step(2);
    check("rst_held", outs(), ev(0, 0, 0, 0, 0));
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("rst_after", outs(), ev(0, 0, 0, 0, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/activity_controller.md
# activity_controller

Front-end stage that directly feeds `fitness_tracker`. It turns four raw, bouncing push buttons (run, walk, cycle, stop) into one mutually exclusive activity state, and generates a one-second time base. Per elapsed second it emits a one-cycle `Run`/`Walk`/`Cycle` enable pulse. Those pulses drive the tracker's activity inputs directly, so each tracker counter advances exactly once per real second. It also keeps a saturating total of active seconds for the display.

## Interface
Parameters:
- `TICK_DIV`, default 100: clock cycles per second tick. Legal range is 2..65535.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples needed to accept a level change. Legal range is 1..255.

Ports:
- `clk`, input, 1: single system clock. All logic is on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset. It asserts asynchronously and releases on the clock.
- `btn_run`, `btn_walk`, `btn_cycle`, `btn_stop`, inputs, 1 each: raw asynchronous button levels, active high.
- `Run`, `Walk`, `Cycle`, outputs, 1 each: registered one-cycle pulse per completed second of that activity.
- `active`, output, 2: current state. IDLE=0, RUN=1, WALK=2, CYCLE=3.
- `sec_tick`, output, 1: registered one-cycle pulse per completed second in any non-IDLE state.
- `active_seconds`, output, 16: total seconds spent in non-IDLE states, saturating.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer giving `s_x`.
- **Debouncer:** each button has an 8-bit counter `cnt_x` and a debounced level `db_x`.
  - If `s_x == db_x`, then `cnt_x` is set to 0.
  - Otherwise `cnt_x` increments. On the edge where it would reach `DEBOUNCE_CYCLES`, `db_x` takes `s_x` and `cnt_x` is set to 0.
- **Press event:** a press is the edge where `db_x` goes 0→1, evaluated from the next-state value. Releases generate no event.
- **Simultaneous presses** resolve by priority: stop > run > walk > cycle. Only the winning press is acted on.
- **FSM transitions:**
  - stop press: any state → IDLE.
  - run press: RUN → IDLE (pause toggle); any other state → RUN.
  - walk press: WALK → IDLE; any other state → WALK.
  - cycle press: CYCLE → IDLE; any other state → CYCLE.
  - No press: hold the current state.
- **Divider:** 16-bit `div`.
  - Cleared to 0 on every edge that changes `active`.
  - Held at 0 while IDLE.
  - Otherwise counts 0..`TICK_DIV`-1 and wraps.
- **Tick generation:** on the edge where `div == TICK_DIV-1` with no state change on that same edge:
  - `sec_tick` and the pulse matching the current state are registered high for exactly one cycle.
  - `active_seconds` increments, saturating at 65535.
- **Interrupted seconds:** a state change on the wrap edge wins. No pulse is produced and the partial second is discarded. The new activity always starts a full `TICK_DIV`-cycle second.
- **Output exclusivity:** at most one of `Run`/`Walk`/`Cycle` is high in any cycle. All three stay low in IDLE.
- **Held buttons:** a button held through reset release yields a press once it is debounced, because `db_x` resets to 0.

## Timing
- **Reset (`rst` = 0):**
  - `active` = 0, `Run` = `Walk` = `Cycle` = 0, `sec_tick` = 0, `active_seconds` = 0.
  - Synchronizers, `db_x`, `cnt_x` and `div` are all 0.
- **Press latency:** let a raw button rise be first sampled at edge E1. `active` changes at edge E(2+`DEBOUNCE_CYCLES`). With defaults this is 6 edges.
- **Bounce rejection:** a glitch lasting fewer than `DEBOUNCE_CYCLES` synchronized cycles causes no state change.
- **First pulse:** after entering an active state at edge T, the first pulse is high in the cycle after edge T+`TICK_DIV`. Later pulses follow every `TICK_DIV` cycles.
- **Reset mid-second:** all state clears immediately and no pulse is emitted.
- **Pulse width:** exactly 1 clock. The pulses are registered, so no combinational path exists from the buttons to the outputs.

## Test plan
Run with `TICK_DIV`=10 and `DEBOUNCE_CYCLES`=4.

1. **Reset and idle:** hold `rst`=0, then release with all buttons low for 50 cycles → all outputs stay 0 and `active`=0 throughout.
2. **Clean run press:** `btn_run` rises (first sampled at E1) and is held for 20 cycles, then 35 more cycles elapse.
   - `active`=1 at E6.
   - `Run` pulses after E16, E26, E36 and E46.
   - `Walk`=`Cycle`=0 throughout.
   - `active_seconds`=4 after E46.
3. **Bounce:** `btn_walk` toggles every 2 cycles for 20 cycles, then stays low → `active` is unchanged and no pulses occur.
4. **Switch, priority and pause:**
   - In RUN with `div`=7, press `btn_cycle` → on the change edge `active`=3 and `div`=0, with no `Run` pulse for the partial second. The first `Cycle` pulse follows 10 cycles later.
   - `btn_run` and `btn_stop` debounced on the same edge → `active`=0.
   - In WALK, press `btn_walk` again → `active`=0.
5. **Saturation and reset:**
   - Force `active_seconds`=65534 in RUN (or run long enough to reach it) → after 2 more ticks it reads 65535, and `Run` keeps pulsing.
   - Assert `rst`=0 mid-second → all outputs are 0 immediately.
